// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// State encoding, default timeouts and a width helper.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCEPT    = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_START_TIMEOUT = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick
  import uart_sched_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < int'(N); k++) begin
      j = IW'((int'(ptr) + k) % int'(N));
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NUM_REQ byte streams,
// round-robin with packet lock and start/busy handshake.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 err_timeout
);

  localparam int unsigned IW = clog2(NUM_REQ);
  localparam int unsigned LW = clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = clog2(START_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      own_q, own_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               lock_q, lock_d;
  logic [LW-1:0]      lcnt_q, lcnt_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               start_q, start_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic [IW-1:0]      own_nxt;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (own_q == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*8 +: 8];
      end
    end
  end

  assign own_nxt = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + IW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    lcnt_d  = lcnt_q;
    scnt_d  = scnt_q;
    data_d  = data_q;
    last_d  = last_q;
    start_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // Never accept while a frame (e.g. one cut by reset) is still on the wire.
        if (lock_q) begin
          if (sel_valid) begin
            lcnt_d = '0;
            if (!tx_busy) state_d = ACCEPT;
          end else if (lcnt_q == LW'(LOCK_TIMEOUT - 1)) begin
            lock_d  = 1'b0;
            lcnt_d  = '0;
            grant_d = '0;
            ptr_d   = own_nxt;
          end else begin
            lcnt_d = lcnt_q + LW'(1);
          end
        end else if (pick_any && !tx_busy) begin
          grant_d = pick_gnt;
          own_d   = pick_idx;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (sel_valid) begin
          data_d  = sel_data;
          last_d  = sel_last;
          start_d = 1'b1;
          state_d = START;
        end else begin
          if (!lock_q) grant_d = '0;
          state_d = IDLE;
        end
      end
      START: begin
        scnt_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (scnt_q == SW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          grant_d = '0;
          ptr_d   = own_nxt;
          state_d = IDLE;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          lcnt_d  = '0;
          if (last_q) begin
            lock_d  = 1'b0;
            grant_d = '0;
            ptr_d   = own_nxt;
          end else begin
            lock_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      lcnt_q  <= '0;
      scnt_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      lcnt_q  <= lcnt_d;
      scnt_q  <= scnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  // Strobe only when the owner still offers a byte in ACCEPT.
  assign req_ready   = (state_q == ACCEPT) ? (grant_q & req_valid) : '0;
  assign grant       = grant_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign err_timeout = err_q;

endmodule
